// File: rtl/mux_scan_sequencer.sv
// Steps the 7:1 mux select through 0..6 with a programmable dwell, sampling
// the mux output at the end of each dwell and assembling a 7-bit snapshot word.
module mux_scan_sequencer #(
  parameter int TICK_DIV   = 25000000,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
  output logic [2:0] select,
  output logic [6:0] word,
  output logic       word_valid,
  output logic       busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0] LAST_SEL = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t           r_state, w_nextState;
  logic [CNT_W-1:0] r_cnt, w_nextCnt;
  logic [2:0]       r_sel, w_nextSel;
  logic [6:0]       r_cap, w_nextCap;
  logic [6:0]       r_word, w_nextWord;
  logic             r_valid, w_nextValid;
  logic             r_busy, w_nextBusy;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_cap   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_sel   <= w_nextSel;
      r_cap   <= w_nextCap;
      r_word  <= w_nextWord;
      r_valid <= w_nextValid;
      r_busy  <= w_nextBusy;
    end
  end

  // abort outranks the final sample, so an aborted scan never touches word
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextSel   = r_sel;
    w_nextCap   = r_cap;
    w_nextWord  = r_word;
    w_nextValid = 1'b0;
    w_nextBusy  = r_busy;

    unique case (r_state)
      IDLE: begin
        w_nextSel  = '0;
        w_nextBusy = 1'b0;
        if (start && !abort) begin
          w_nextState = DRIVE;
          w_nextCnt   = '0;
          w_nextCap   = '0;
          w_nextBusy  = 1'b1;
        end
      end

      DRIVE: begin
        if (abort) begin
          w_nextState = IDLE;
          w_nextSel   = '0;
          w_nextCnt   = '0;
          w_nextBusy  = 1'b0;
        end else if (r_cnt == LAST_CNT) begin
          w_nextCnt        = '0;
          w_nextCap[r_sel] = mux_out;
          if (r_sel != LAST_SEL) begin
            w_nextSel = r_sel + 3'd1;
          end else begin
            w_nextWord  = {mux_out, r_cap[5:0]};
            w_nextValid = 1'b1;
            w_nextSel   = '0;
            if (CONTINUOUS) begin
              w_nextCap = '0;
            end else begin
              w_nextState = IDLE;
              w_nextBusy  = 1'b0;
            end
          end
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign select     = r_sel;
  assign word       = r_word;
  assign word_valid = r_valid;
  assign busy       = r_busy;

endmodule
